mux_stream_n: RTL and testbench

//  - Parametrised N-channel, W-bit packet multiplexer: successor to the combinational 4:1 select mux.
//  - Adds a valid/ready handshake, packet locking (a grant is held until in_last), round-robin or external-select mode, and a registered output.
//  - Sits between N independent packet sources and a single downstream sink (e.g. a shared UART/bus).

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_stream_n_rr_pick.sv | 33 +++
 rtl/mux_stream_n.sv | 141 ++++++++++++++
 tb/tb_mux_stream_n.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-channel packet multiplexer.
package mux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width that stays at least one bit wide for single-channel builds.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_stream_n_rr_pick.sv
// Round-robin picker: first requesting channel after ptr, wrapping modulo N.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int          cand;
  logic [N-1:0] reqShift;

  // Scan ptr+1, ptr+2, ... so the channel served last has lowest priority.
  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    reqShift = '0;
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(ptr) + i) % N;
      reqShift = req >> cand;
      if (!gnt_any && reqShift[0]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready packet multiplexer with packet locking, round-robin or
// external select, and a registered output stage.
module mux_stream_n
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = MODE_RR,
  localparam int SELW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic            out_last,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_src,
  input  logic            out_ready
);

  state_e          state_q, state_d;
  logic [SELW-1:0] lockCh_q, lockCh_d;
  logic [SELW-1:0] rrPtr_q, rrPtr_d;
  logic            outValid_q, outValid_d;
  logic            outLast_q, outLast_d;
  logic [W-1:0]    outData_q, outData_d;
  logic [SELW-1:0] outSrc_q, outSrc_d;

  logic [SELW-1:0] rrIdx;
  logic            rrAny;
  logic            selValid;
  logic [SELW-1:0] grant;
  logic            candOk;
  logic            ld;
  logic            xfer;
  logic [W-1:0]    xferData;
  logic            xferLast;

  rr_pick #(.N(N)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rrPtr_q),
    .gnt_idx (rrIdx),
    .gnt_any (rrAny)
  );

  assign ld = !outValid_q || out_ready;

  // A locked packet owns the output regardless of its own valid; otherwise
  // the arbiter or the select port nominates a channel.
  always_comb begin
    selValid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) selValid = in_valid[k];
    end
    grant  = '0;
    candOk = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant  = lockCh_q;
      candOk = 1'b1;
    end else if (MODE == MODE_RR) begin
      grant  = rrIdx;
      candOk = rrAny;
    end else begin
      grant  = sel;
      candOk = selValid;
    end
  end

  always_comb begin
    in_ready = '0;
    xferData = '0;
    xferLast = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant == SELW'(k)) begin
        in_ready[k] = ld && candOk && !rst;
        xferData    = in_data[k*W +: W];
        xferLast    = in_last[k];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // The round-robin pointer moves only on end-of-packet for packet fairness.
  always_comb begin
    state_d    = state_q;
    lockCh_d   = lockCh_q;
    rrPtr_d    = rrPtr_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    outData_d  = outData_q;
    outSrc_d   = outSrc_q;
    if (ld) begin
      if (xfer) begin
        outValid_d = 1'b1;
        outData_d  = xferData;
        outLast_d  = xferLast;
        outSrc_d   = grant;
        if (xferLast) begin
          state_d = ST_IDLE;
          rrPtr_d = grant;
        end else begin
          state_d  = ST_LOCKED;
          lockCh_d = grant;
        end
      end else begin
        outValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lockCh_q   <= '0;
      rrPtr_q    <= SELW'(N - 1);
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= '0;
    end else begin
      state_q    <= state_d;
      lockCh_q   <= lockCh_d;
      rrPtr_q    <= rrPtr_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      outData_q  <= outData_d;
      outSrc_q   <= outSrc_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign out_data  = outData_q;
  assign out_src   = outSrc_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Bench for mux_stream_n: packet-level model checked every cycle on a
// round-robin and a select-mode instance, plus directed literal checks.
module tb_mux_stream_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic [1:0]  sel3 = 2'd3;
  logic        outReady = 1'b1;
  logic [3:0]  inValid, inLast;
  logic [31:0] inData;

  logic [3:0]  readyR, readyS;
  logic        validR, validS, lastR, lastS;
  logic [7:0]  dataR, dataS;
  logic [1:0]  srcR, srcS;
  logic [2:0]  ready3;
  logic        valid3, last3;
  logic [7:0]  data3;
  logic [1:0]  src3;

  always #5 clk = ~clk;

  mux_stream_n #(.N(4), .W(8), .MODE(1)) dutRr (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(inValid), .in_last(inLast),
    .in_data(inData), .in_ready(readyR), .out_valid(validR), .out_last(lastR),
    .out_data(dataR), .out_src(srcR), .out_ready(outReady)
  );

  mux_stream_n #(.N(4), .W(8), .MODE(0)) dutSel (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(inValid), .in_last(inLast),
    .in_data(inData), .in_ready(readyS), .out_valid(validS), .out_last(lastS),
    .out_data(dataS), .out_src(srcS), .out_ready(outReady)
  );

  mux_stream_n #(.N(3), .W(8), .MODE(0)) dut3 (
    .clk(clk), .rst(rst), .sel(sel3), .in_valid(3'b111), .in_last(3'b111),
    .in_data(24'hCCBBAA), .in_ready(ready3), .out_valid(valid3), .out_last(last3),
    .out_data(data3), .out_src(src3), .out_ready(1'b1)
  );

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet sources: channel k emits data {k, running count}, pktLen beats per packet.
  logic [3:0] srcEn = 4'h0;
  bit         useSel = 1'b0;
  int pktLen[4];
  int quota[4];
  int beat[4];
  int cnt[4];
  int done[4];

  always_comb begin
    inValid = '0;
    inLast  = '0;
    inData  = '0;
    for (int k = 0; k < 4; k++) begin
      inValid[k]        = srcEn[k] && (done[k] < quota[k]);
      inLast[k]         = (beat[k] == pktLen[k] - 1);
      inData[k*8 +: 8]  = {2'(k), 6'(cnt[k])};
    end
  end

  always @(posedge clk) begin : sources
    logic [3:0] rdy;
    rdy = useSel ? readyS : readyR;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        beat[k] <= 0;
        cnt[k]  <= 0;
        done[k] <= 0;
      end else if (inValid[k] && rdy[k]) begin
        cnt[k] <= cnt[k] + 1;
        if (inLast[k]) begin
          beat[k] <= 0;
          done[k] <= done[k] + 1;
        end else begin
          beat[k] <= beat[k] + 1;
        end
      end
    end
  end

  // Behavioural model, index 0 = round-robin instance, 1 = select instance.
  bit         modelOn = 1'b0;
  bit         mLocked[2];
  int         mLock[2];
  int         mPtr[2];
  logic       mValid[2];
  logic       mLast[2];
  logic [7:0] mData[2];
  int         mSrc[2];

  function automatic logic [3:0] expReady(input int inst);
    if (rst) return 4'h0;
    if (mValid[inst] && !outReady) return 4'h0;
    if (mLocked[inst]) return 4'(1) << mLock[inst];
    if (inst == 0) begin
      for (int i = 1; i <= 4; i++) begin
        int c = (mPtr[inst] + i) % 4;
        if (inValid[c]) return 4'(1) << c;
      end
      return 4'h0;
    end
    if (inValid[sel]) return 4'(1) << sel;
    return 4'h0;
  endfunction

  always @(posedge clk) begin : modelUpdate
    logic [3:0] r;
    for (int inst = 0; inst < 2; inst++) begin
      r = expReady(inst);
      if (rst) begin
        mLocked[inst] = 1'b0;
        mLock[inst]   = 0;
        mPtr[inst]    = 3;
        mValid[inst]  = 1'b0;
        mLast[inst]   = 1'b0;
        mData[inst]   = 8'h00;
        mSrc[inst]    = 0;
      end else if (!mValid[inst] || outReady) begin
        mValid[inst] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (r[k] && inValid[k]) begin
            mValid[inst] = 1'b1;
            mData[inst]  = inData[k*8 +: 8];
            mLast[inst]  = inLast[k];
            mSrc[inst]   = k;
            if (inLast[k]) begin
              mLocked[inst] = 1'b0;
              mPtr[inst]    = k;
            end else begin
              mLocked[inst] = 1'b1;
              mLock[inst]   = k;
            end
          end
        end
      end
    end
    if (rst) modelOn = 1'b1;
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("rrReady", 32'(readyR), 32'(expReady(0)));
      checkOutput("rrValid", 32'(validR), 32'(mValid[0]));
      checkOutput("rrData",  32'(dataR),  32'(mData[0]));
      checkOutput("rrLast",  32'(lastR),  32'(mLast[0]));
      checkOutput("rrSrc",   32'(srcR),   32'(mSrc[0]));
      checkOutput("selReady", 32'(readyS), 32'(expReady(1)));
      checkOutput("selValid", 32'(validS), 32'(mValid[1]));
      checkOutput("selData",  32'(dataS),  32'(mData[1]));
      checkOutput("selLast",  32'(lastS),  32'(mLast[1]));
      checkOutput("selSrc",   32'(srcS),   32'(mSrc[1]));
    end
  end

  // Accepted output beats of the instance currently driving the sources.
  logic [9:0] got[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (useSel) begin
        if (validS && outReady) got.push_back({srcS, dataS});
      end else begin
        if (validR && outReady) got.push_back({srcR, dataR});
      end
    end
  end

  task automatic checkBeats(input string name, input logic [9:0] exp[], input int n);
    checkOutput({name, "Count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      checkOutput(name, 32'((i < got.size()) ? got[i] : 10'h3FF), 32'(exp[i]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] en, input logic ordy,
                               input logic [1:0] s, input int cycles);
    rst      = r;
    srcEn    = en;
    outReady = ordy;
    sel      = s;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setSources(input int l0, input int l1, input int l2, input int l3,
                            input int q0, input int q1, input int q2, input int q3);
    pktLen[0] = l0; pktLen[1] = l1; pktLen[2] = l2; pktLen[3] = l3;
    quota[0]  = q0; quota[1]  = q1; quota[2]  = q2; quota[3]  = q3;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] expRr[]   = '{10'h000, 10'h140, 10'h280, 10'h3C0, 10'h001, 10'h141, 10'h281, 10'h3C1};
    logic [9:0] expLock[] = '{10'h280, 10'h281, 10'h282, 10'h3C0, 10'h000, 10'h140, 10'h3C1, 10'h001};
    logic [9:0] expBp[]   = '{10'h140, 10'h141, 10'h142, 10'h143, 10'h144, 10'h145};
    logic [9:0] expSel[]  = '{10'h140, 10'h141, 10'h142, 10'h3C0, 10'h3C1};

    // Reset with all sources active, then continuous single-beat round robin.
    setSources(1, 1, 1, 1, 1000, 1000, 1000, 1000);
    useSel = 1'b0;
    applyStimulus(1'b1, 4'hF, 1'b1, 2'd0, 1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rstReady", 32'(readyR), 32'h0);
      checkOutput("rstValid", 32'(validR), 32'h0);
      checkOutput("rstData",  32'(dataR),  32'h0);
      @(posedge clk);
      #2;
    end
    got.delete();
    applyStimulus(1'b0, 4'hF, 1'b1, 2'd0, 0);
    @(negedge clk);
    checkOutput("firstGrant", 32'(readyR), 32'h1);
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 4'hF, 1'b1, 2'd0, 8);
    checkBeats("rrSeq", expRr, 8);

    // Three-beat packet on ch2 holds the grant against ch0/ch1.
    setSources(1, 1, 3, 1, 1000, 1000, 1, 1000);
    applyStimulus(1'b1, 4'h0, 1'b1, 2'd0, 2);
    got.delete();
    applyStimulus(1'b0, 4'b0100, 1'b1, 2'd0, 1);
    applyStimulus(1'b0, 4'hF, 1'b1, 2'd0, 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("lockReady", 32'(readyR), 32'h4);
      @(posedge clk);
      #2;
    end
    applyStimulus(1'b0, 4'hF, 1'b1, 2'd0, 6);
    checkBeats("lockSeq", expLock, 8);

    // Four cycles of backpressure in the middle of a six-beat packet.
    setSources(1, 6, 1, 1, 1000, 1, 1000, 1000);
    applyStimulus(1'b1, 4'h0, 1'b1, 2'd0, 2);
    got.delete();
    applyStimulus(1'b0, 4'b0010, 1'b1, 2'd0, 2);
    applyStimulus(1'b0, 4'b0010, 1'b0, 2'd0, 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("bpData",  32'(dataR),  32'h41);
      checkOutput("bpValid", 32'(validR), 32'h1);
      checkOutput("bpReady", 32'(readyR), 32'h0);
      @(posedge clk);
      #2;
    end
    applyStimulus(1'b0, 4'b0010, 1'b1, 2'd0, 5);
    checkBeats("bpSeq", expBp, 6);

    // Select mode: sel moves from 1 to 3 while ch1's packet is in flight.
    setSources(1, 3, 1, 1, 1000, 1, 1000, 1000);
    useSel = 1'b1;
    applyStimulus(1'b1, 4'h0, 1'b1, 2'd1, 2);
    got.delete();
    applyStimulus(1'b0, 4'b1010, 1'b1, 2'd1, 1);
    applyStimulus(1'b0, 4'b1010, 1'b1, 2'd3, 0);
    @(negedge clk);
    checkOutput("selLockReady", 32'(readyS), 32'h2);
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 4'b1010, 1'b1, 2'd3, 4);
    checkBeats("selSeq", expSel, 5);

    // Reset pulse while locked on ch1 drops the held beat and the lock.
    setSources(1, 5, 1, 1, 1000, 1, 1000, 1000);
    useSel = 1'b0;
    applyStimulus(1'b1, 4'h0, 1'b1, 2'd0, 2);
    applyStimulus(1'b0, 4'b0010, 1'b1, 2'd0, 2);
    applyStimulus(1'b1, 4'b0011, 1'b1, 2'd0, 0);
    @(negedge clk);
    checkOutput("midRstReady", 32'(readyR), 32'h0);
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 4'b0011, 1'b1, 2'd0, 0);
    @(negedge clk);
    checkOutput("midRstValid", 32'(validR), 32'h0);
    checkOutput("midRstGrant", 32'(readyR), 32'h1);
    @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("postRstSrc",  32'(srcR),  32'h0);
    checkOutput("postRstData", 32'(dataR), 32'h00);
    @(posedge clk);
    #2;

    // Three-channel select instance: an out-of-range select never grants.
    sel3 = 2'd3;
    applyStimulus(1'b1, 4'h0, 1'b1, 2'd0, 2);
    applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 2);
    @(negedge clk);
    checkOutput("oorReady", 32'(ready3), 32'h0);
    checkOutput("oorValid", 32'(valid3), 32'h0);
    @(posedge clk);
    #2;
    sel3 = 2'd2;
    @(negedge clk);
    checkOutput("sel3Ready", 32'(ready3), 32'h4);
    @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("sel3Valid", 32'(valid3), 32'h1);
    checkOutput("sel3Data",  32'(data3),  32'hCC);
    checkOutput("sel3Src",   32'(src3),   32'h2);
    checkOutput("sel3Last",  32'(last3),  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
